// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: default 640x480@60 Hz constants, the
// sync/blank bundle carried through the alignment pipeline, and the helper
// used to derive total line/frame lengths from the porch/sync widths.
package vga_pkg;

  localparam int CNT_W   = 10;
  localparam int COLOR_W = 10;

  localparam int DEF_H_ACTIVE   = 640;
  localparam int DEF_H_FP       = 16;
  localparam int DEF_H_SYNC     = 96;
  localparam int DEF_H_BP       = 48;
  localparam int DEF_V_ACTIVE   = 480;
  localparam int DEF_V_FP       = 10;
  localparam int DEF_V_SYNC     = 2;
  localparam int DEF_V_BP       = 33;
  localparam int DEF_PIPE_DELAY = 2;

  // Sync/blank bundle; hs and vs are active-low, de is high in active video.
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_bits_t;

  localparam sync_bits_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0};

  function automatic int calc_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Pixel-tick enabled shift register that delays {hs, vs, de} so the sync
// and blank signals line up with RGB returning from the framebuffer logic.
// A depth of zero is a straight wire.
module vga_sync_delay
  import vga_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  sync_bits_t din,
  output sync_bits_t dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_bypass;
      assign unused_bypass = ^{clock, reset_n, enable};
      assign dout = din;
    end else begin : g_shift
      sync_bits_t [DEPTH-1:0] stages;

      // Shift one stage per pixel tick; reset fills the line with idle timing
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < DEPTH; i++) stages[i] <= SYNC_IDLE;
        end else if (enable) begin
          stages[0] <= din;
          for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
      end

      assign dout = stages[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator and DAC output stage. Divides the 50 MHz clock into
// a 25 MHz pixel tick, walks the h/v raster, exports the visible address to
// the framebuffer logic, and registers returning RGB onto the DAC pins with
// sync/blank delayed to match the framebuffer read latency.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int PIPE_DELAY = DEF_PIPE_DELAY
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [COLOR_W-1:0] vga_r,
  input  logic [COLOR_W-1:0] vga_g,
  input  logic [COLOR_W-1:0] vga_b,
  output logic [CNT_W-1:0]   x_addr,
  output logic [CNT_W-1:0]   y_addr,
  output logic               pixel_tick,
  output logic               frame_start,
  output logic [COLOR_W-1:0] vga_r_DAC,
  output logic [COLOR_W-1:0] vga_g_DAC,
  output logic [COLOR_W-1:0] vga_b_DAC,
  output logic               vga_clock,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic               vga_blank,
  output logic               vga_sync_dac
);

  localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] H_ACT_C    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_LAST_C   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST_C   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HS_START_C = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END_C   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START_C = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END_C   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
      $error("vga_timing_gen: line or frame total does not fit the 10-bit counters");
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > 4) begin : g_delay_check
      $error("vga_timing_gen: PIPE_DELAY must be within 0..4");
    end
  endgenerate

  logic             phase;
  logic [CNT_W-1:0] h_count;
  logic [CNT_W-1:0] v_count;
  logic             h_active;
  logic             v_active;
  logic             hs_low;
  logic             vs_low;
  sync_bits_t       raw_q;
  sync_bits_t       sync_dly;

  assign h_active     = (h_count < H_ACT_C);
  assign v_active     = (v_count < V_ACT_C);
  assign hs_low       = (h_count >= HS_START_C) && (h_count < HS_END_C);
  assign vs_low       = (v_count >= VS_START_C) && (v_count < VS_END_C);
  assign vga_sync_dac = 1'b0;

  // Divide by two: pixel_tick strobes once per pixel, vga_clock rises mid-pixel
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase      <= 1'b0;
      pixel_tick <= 1'b0;
      vga_clock  <= 1'b0;
    end else begin
      phase      <= ~phase;
      pixel_tick <= phase;
      vga_clock  <= phase;
    end
  end

  // Raster position: h wraps every line, v steps on each h wrap
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      h_count <= '0;
      v_count <= '0;
    end else if (pixel_tick) begin
      if (h_count == H_LAST_C) begin
        h_count <= '0;
        v_count <= (v_count == V_LAST_C) ? '0 : v_count + 1'b1;
      end else begin
        h_count <= h_count + 1'b1;
      end
    end
  end

  // Register the visible address and raw sync/blank for the current position
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x_addr      <= '0;
      y_addr      <= '0;
      frame_start <= 1'b0;
      raw_q       <= SYNC_IDLE;
    end else begin
      frame_start <= pixel_tick && (h_count == '0) && (v_count == '0);
      if (pixel_tick) begin
        x_addr <= h_active ? h_count : '0;
        y_addr <= v_active ? v_count : '0;
        raw_q  <= '{hs: ~hs_low, vs: ~vs_low, de: h_active && v_active};
      end
    end
  end

  vga_sync_delay #(
    .DEPTH (PIPE_DELAY)
  ) u_sync_delay (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (pixel_tick),
    .din     (raw_q),
    .dout    (sync_dly)
  );

  // DAC output register: RGB is gated to black whenever the pixel is blanked
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vga_hs    <= 1'b1;
      vga_vs    <= 1'b1;
      vga_blank <= 1'b0;
      vga_r_DAC <= '0;
      vga_g_DAC <= '0;
      vga_b_DAC <= '0;
    end else if (pixel_tick) begin
      vga_hs    <= sync_dly.hs;
      vga_vs    <= sync_dly.vs;
      vga_blank <= sync_dly.de;
      vga_r_DAC <= sync_dly.de ? vga_r : '0;
      vga_g_DAC <= sync_dly.de ? vga_g : '0;
      vga_b_DAC <= sync_dly.de ? vga_b : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen using a reduced raster so whole
// frames fit in a short run. Expected outputs come from pixel-index
// arithmetic: tick n addresses pixel n mod frame, and the DAC shows pixel
// n-PIPE_DELAY-1 with whatever RGB was on the inputs at that tick.
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
  localparam int PD = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] vga_r = '0, vga_g = '0, vga_b = '0;
  logic [9:0] x_addr, y_addr, vga_r_DAC, vga_g_DAC, vga_b_DAC;
  logic       pixel_tick, frame_start, vga_clock, vga_hs, vga_vs, vga_blank, vga_sync_dac;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .PIPE_DELAY(PD)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .x_addr(x_addr), .y_addr(y_addr),
    .pixel_tick(pixel_tick), .frame_start(frame_start),
    .vga_r_DAC(vga_r_DAC), .vga_g_DAC(vga_g_DAC), .vga_b_DAC(vga_b_DAC),
    .vga_clock(vga_clock), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_blank(vga_blank), .vga_sync_dac(vga_sync_dac)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  int clk_cnt, tick_n, mode;
  logic [9:0] exp_x, exp_y, exp_r, exp_g, exp_b;
  logic exp_hs, exp_vs, exp_blank;
  int prev_hs, prev_vs, hs_fall, vs_fall, last_fs, fs_seen;

  function automatic int hOf(input int n); return n % HT; endfunction
  function automatic int vOf(input int n); return (n / HT) % VT; endfunction
  function automatic bit deOf(input int n); return (hOf(n) < HA) && (vOf(n) < VA); endfunction
  function automatic bit hsOf(input int n); return !((hOf(n) >= HA + HF) && (hOf(n) < HA + HF + HS)); endfunction
  function automatic bit vsOf(input int n); return !((vOf(n) >= VA + VF) && (vOf(n) < VA + VF + VS)); endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic resetModel();
    clk_cnt = 0; tick_n = -1;
    exp_x = '0; exp_y = '0; exp_r = '0; exp_g = '0; exp_b = '0;
    exp_hs = 1'b1; exp_vs = 1'b1; exp_blank = 1'b0;
    prev_hs = 1; prev_vs = 1; hs_fall = -1; vs_fall = -1; last_fs = -1; fs_seen = 0;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_tick"},  pixel_tick, 0);
    checkOutput({tag, "_fs"},    frame_start, 0);
    checkOutput({tag, "_x"},     x_addr, 0);
    checkOutput({tag, "_y"},     y_addr, 0);
    checkOutput({tag, "_hs"},    vga_hs, 1);
    checkOutput({tag, "_vs"},    vga_vs, 1);
    checkOutput({tag, "_blank"}, vga_blank, 0);
    checkOutput({tag, "_vclk"},  vga_clock, 0);
    checkOutput({tag, "_rgb"},   {vga_r_DAC, vga_g_DAC, vga_b_DAC}, 0);
  endtask

  // Drive RGB for the pixel addressed PD ticks ago; mode chosen per line.
  task automatic applyStimulus(input int m);
    int k;
    k = m - PD;
    if (hOf(m) == 0) mode = $urandom_range(0, 2);
    case (mode)
      0: begin
        vga_r = (k >= 0 && hOf(k) < HA) ? 10'(hOf(k)) : 10'($urandom);
        vga_g = ~vga_r;
        vga_b = 10'($urandom);
      end
      1: begin
        vga_r = 10'($urandom); vga_g = 10'($urandom); vga_b = 10'($urandom);
      end
      default: begin
        vga_r = 10'h3ff; vga_g = 10'h3ff; vga_b = 10'h3ff;
      end
    endcase
  endtask

  // Advance one clock, update the model, compare every output.
  task automatic stepClock(output bit is_tick);
    int k;
    @(posedge clock); #1;
    clk_cnt++;
    is_tick = (clk_cnt >= 3) && (clk_cnt % 2 == 1);
    if (is_tick) begin
      tick_n = (clk_cnt - 3) / 2;
      exp_x = (hOf(tick_n) < HA) ? 10'(hOf(tick_n)) : '0;
      exp_y = (vOf(tick_n) < VA) ? 10'(vOf(tick_n)) : '0;
      k = tick_n - PD - 1;
      if (k >= 0) begin
        exp_hs = hsOf(k); exp_vs = vsOf(k); exp_blank = deOf(k);
        exp_r = deOf(k) ? vga_r : '0;
        exp_g = deOf(k) ? vga_g : '0;
        exp_b = deOf(k) ? vga_b : '0;
      end
    end
    checkOutput("pixel_tick", pixel_tick, (clk_cnt >= 2) && (clk_cnt % 2 == 0));
    checkOutput("vga_clock", vga_clock, (clk_cnt >= 2) && (clk_cnt % 2 == 0));
    checkOutput("frame_start", frame_start, is_tick && (tick_n % FT == 0));
    checkOutput("x_addr", x_addr, exp_x);
    checkOutput("y_addr", y_addr, exp_y);
    checkOutput("vga_hs", vga_hs, exp_hs);
    checkOutput("vga_vs", vga_vs, exp_vs);
    checkOutput("vga_blank", vga_blank, exp_blank);
    checkOutput("vga_r_DAC", vga_r_DAC, exp_r);
    checkOutput("vga_g_DAC", vga_g_DAC, exp_g);
    checkOutput("vga_b_DAC", vga_b_DAC, exp_b);
    checkOutput("vga_sync_dac", vga_sync_dac, 0);
    if (is_tick) begin
      if (prev_hs == 1 && vga_hs == 1'b0) begin
        if (hs_fall >= 0) checkOutput("hs_period", tick_n - hs_fall, HT);
        hs_fall = tick_n;
      end
      if (prev_hs == 0 && vga_hs == 1'b1 && hs_fall >= 0) checkOutput("hs_width", tick_n - hs_fall, HS);
      if (prev_vs == 1 && vga_vs == 1'b0) begin
        if (vs_fall >= 0) checkOutput("vs_period", tick_n - vs_fall, FT);
        vs_fall = tick_n;
      end
      if (prev_vs == 0 && vga_vs == 1'b1 && vs_fall >= 0) checkOutput("vs_width", tick_n - vs_fall, VS * HT);
      prev_hs = vga_hs; prev_vs = vga_vs;
      applyStimulus(tick_n);
    end
    if (frame_start) begin
      if (last_fs >= 0) checkOutput("fs_period", tick_n - last_fs, FT);
      last_fs = tick_n; fs_seen++;
    end
  endtask

  initial begin
    bit t;
    mode = 1;
    resetModel();
    vga_r = 10'($urandom); vga_g = 10'($urandom); vga_b = 10'($urandom);
    repeat (3) @(posedge clock);
    #1 checkReset("por");

    @(negedge clock);
    reset_n = 1'b1;
    resetModel();
    // Two full frames, then stop while the raster sits mid-line in the active area.
    while (!(tick_n == 2 * FT + 5 * HT + 10)) stepClock(t);
    checkOutput("pre_reset_x", x_addr, 10);
    checkOutput("pre_reset_y", y_addr, 5);
    checkOutput("fs_count_a", fs_seen, 3);

    #2 reset_n = 1'b0;
    #1 checkReset("midrst");
    repeat (2) @(posedge clock);
    #1 checkReset("midrst_hold");

    @(negedge clock);
    reset_n = 1'b1;
    resetModel();
    repeat (2 * (FT + 3 * HT) + 3) stepClock(t);
    checkOutput("fs_count_b", fs_seen, 2);
    checkOutput("fs_last_tick", last_fs, FT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
